// File: rtl/echo_detector_if.sv
// Bus bundle for echo_detector: sample/control inputs from the FIR side, results back.
interface echo_detector_if #(
  parameter int unsigned N     = 16,
  parameter int unsigned CNT_W = 16
) ();
  logic             en;
  logic [N-1:0]     X;
  logic             start;
  logic [N-1:0]     threshold;
  logic [CNT_W-1:0] blank;
  logic [CNT_W-1:0] timeout;
  logic [CNT_W-1:0] tof;
  logic [N-1:0]     peak;
  logic             valid;
  logic             timed_out;
  logic             busy;

  modport master (
    output en, X, start, threshold, blank, timeout,
    input  tof, peak, valid, timed_out, busy
  );

  modport slave (
    input  en, X, start, threshold, blank, timeout,
    output tof, peak, valid, timed_out, busy
  );
endinterface

// File: rtl/echo_detector.sv
// Time-of-flight echo detector: blanks, then listens for |X| >= threshold within a window.
// Optional ECHO_DETECTOR_AVG_EN: 4-sample moving average of magnitudes feeds compare/peak.
module echo_detector #(
  parameter int unsigned N     = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  echo_detector_if.slave     bus
);

  localparam logic [N-1:0]     MAG_MAX  = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]     NEG_MAX  = {1'b1, {(N-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, BLANK, LISTEN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tof_q, tof_d;
  logic [N-1:0]     peak_q, peak_d;
  logic             valid_q, valid_d;
  logic             timed_out_q, timed_out_d;
  logic             busy_q, busy_d;

  logic [N-1:0]     raw_mag_c;
  logic [N-1:0]     mag_c;
  logic             tmo_last_c;
  logic             blank_last_c;

  // Saturating absolute value: the most negative code maps to the largest positive.
  always_comb begin
    raw_mag_c = bus.X;
    if (bus.X == NEG_MAX)  raw_mag_c = MAG_MAX;
    else if (bus.X[N-1])   raw_mag_c = N'(~bus.X + N'(1));
  end

`ifdef ECHO_DETECTOR_AVG_EN
  localparam int unsigned SW = N + 2;

  logic [2:0][N-1:0] hist_q, hist_d;
  logic [SW-1:0]     sum_c;

  // hist_q[0] is the most recent accepted magnitude; history spans BLANK too.
  always_comb begin
    sum_c  = SW'(raw_mag_c) + SW'(hist_q[0]) + SW'(hist_q[1]) + SW'(hist_q[2]);
    mag_c  = sum_c[SW-1:2];
    hist_d = hist_q;
    if (bus.start)                      hist_d = '0;
    else if (bus.en && state_q != IDLE) hist_d = {hist_q[1:0], raw_mag_c};
  end

  always_ff @(posedge clk) begin
    if (rst) hist_q <= '0;
    else     hist_q <= hist_d;
  end
`else
  assign mag_c = raw_mag_c;
`endif

  assign tmo_last_c   = (bus.timeout != '0) && (cnt_q == bus.timeout - CNT_W'(1));
  assign blank_last_c = (cnt_q == bus.blank - CNT_W'(1));

  // Next-state and result logic; start overrides any same-cycle sample.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tof_d       = tof_q;
    peak_d      = peak_q;
    valid_d     = 1'b0;
    timed_out_d = 1'b0;

    if (bus.start) begin
      cnt_d   = '0;
      peak_d  = '0;
      state_d = (bus.blank == '0) ? LISTEN : BLANK;
    end else if (bus.en) begin
      unique case (state_q)
        BLANK: begin
          if (tmo_last_c) begin
            tof_d       = CNT_MAX;
            timed_out_d = 1'b1;
            state_d     = IDLE;
          end else if (blank_last_c) begin
            state_d = LISTEN;
          end
        end
        LISTEN: begin
          if (mag_c > peak_q) peak_d = mag_c;
          if (mag_c >= bus.threshold) begin
            tof_d   = cnt_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else if (tmo_last_c) begin
            tof_d       = CNT_MAX;
            timed_out_d = 1'b1;
            state_d     = IDLE;
          end
        end
        default: ;
      endcase
      if (state_q != IDLE && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tof_q       <= '0;
      peak_q      <= '0;
      valid_q     <= 1'b0;
      timed_out_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tof_q       <= tof_d;
      peak_q      <= peak_d;
      valid_q     <= valid_d;
      timed_out_q <= timed_out_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.tof       = tof_q;
  assign bus.peak      = peak_q;
  assign bus.valid     = valid_q;
  assign bus.timed_out = timed_out_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_echo_detector.sv
// Directed bench for echo_detector: a window-level reference model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_echo_detector;

  localparam int unsigned N     = 16;
  localparam int unsigned CNT_W = 16;
  localparam longint      MAXC  = (longint'(1) << CNT_W) - 1;
  localparam int          MAGMX = (1 << (N - 1)) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  echo_detector_if #(.N(N), .CNT_W(CNT_W)) bus ();

  echo_detector #(.N(N), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference state: one measurement window viewed as a list of sample indices.
  bit     m_open;
  longint m_cnt;
  longint m_tof;
  int     m_peak;
  bit     m_valid, m_to;
  int     m_hist[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model(input bit e, input logic [N-1:0] x, input bit s, input bit r);
    longint idx;
    int     xv, mag, eff, sum;
    bit     cmp, hit;
    m_valid = 1'b0;
    m_to    = 1'b0;
    if (r) begin
      m_open = 0; m_cnt = 0; m_tof = 0; m_peak = 0; m_hist.delete();
    end else if (s) begin
      m_open = 1; m_cnt = 0; m_peak = 0; m_hist.delete();
    end else if (e && m_open) begin
      idx = m_cnt;
      xv  = int'($signed(x));
      mag = (xv < 0) ? -xv : xv;
      if (mag > MAGMX) mag = MAGMX;
`ifdef ECHO_DETECTOR_AVG_EN
      m_hist.push_front(mag);
      if (m_hist.size() > 4) void'(m_hist.pop_back());
      sum = 0;
      foreach (m_hist[i]) sum += m_hist[i];
      eff = sum / 4;
`else
      sum = 0;
      eff = mag;
`endif
      cmp = (idx >= longint'(bus.blank));
      hit = cmp && (eff >= int'(bus.threshold));
      if (cmp && eff > m_peak) m_peak = eff;
      if (hit) begin
        m_tof = idx; m_valid = 1; m_open = 0;
      end else if (bus.timeout != 0 && idx == longint'(bus.timeout) - 1) begin
        m_tof = MAXC; m_to = 1; m_open = 0;
      end
      if (m_cnt < MAXC) m_cnt++;
    end
  endtask

  task automatic step(input bit e, input int xv, input bit s, input bit r = 1'b0);
    bus.en    = e;
    bus.X     = N'(xv);
    bus.start = s;
    rst       = r;
    @(posedge clk);
    #1;
    model(e, N'(xv), s, r);
  endtask

  task automatic cfg(input int thr, input int blk, input int tmo);
    bus.threshold = N'(thr);
    bus.blank     = CNT_W'(blk);
    bus.timeout   = CNT_W'(tmo);
  endtask

  // Cycle-by-cycle comparison against the reference model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("tof",       64'(bus.tof),       64'(m_tof));
      chk("peak",      64'(bus.peak),      64'(m_peak));
      chk("valid",     64'(bus.valid),     64'(m_valid));
      chk("timed_out", 64'(bus.timed_out), 64'(m_to));
      chk("busy",      64'(bus.busy),      64'(m_open));
      chk("excl",      64'(bus.valid && bus.timed_out), 64'(0));
    end
  end

  initial begin
    bus.en = 0; bus.X = '0; bus.start = 0; rst = 1;
    cfg(100, 2, 0);
    step(0, 0, 0, 1);
    step(1, 5, 1, 1);
    chk_en = 1'b1;
    chk("rst_tof",   64'(bus.tof),   64'(0));
    chk("rst_peak",  64'(bus.peak),  64'(0));
    chk("rst_valid", 64'(bus.valid), 64'(0));
    chk("rst_busy",  64'(bus.busy),  64'(0));
    step(1, 30000, 0);
    chk("idle_ignored", 64'(bus.valid), 64'(0));

`ifndef ECHO_DETECTOR_AVG_EN
    // Blank two samples then hit at index 3, with an en gap in between.
    cfg(100, 2, 0);
    step(0, 0, 1);
    chk("a_busy", 64'(bus.busy), 64'(1));
    step(1, 10, 0);
    step(0, 999, 0);
    step(1, 20, 0);
    step(1, 30, 0);
    chk("a_noval", 64'(bus.valid), 64'(0));
    step(1, 150, 0);
    chk("a_valid", 64'(bus.valid), 64'(1));
    chk("a_tof",   64'(bus.tof),   64'(3));
    chk("a_peak",  64'(bus.peak),  64'(150));
    step(1, 500, 0);
    chk("a_pulse", 64'(bus.valid), 64'(0));
    chk("a_hold",  64'(bus.tof),   64'(3));

    // Timeout after five sub-threshold samples.
    cfg(1000, 0, 5);
    step(0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 50, 0);
    chk("b_early", 64'(bus.timed_out), 64'(0));
    step(1, 50, 0);
    chk("b_to",    64'(bus.timed_out), 64'(1));
    chk("b_tof",   64'(bus.tof),       64'(16'hFFFF));
    chk("b_peak",  64'(bus.peak),      64'(50));
    chk("b_valid", 64'(bus.valid),     64'(0));
    step(0, 0, 0);

    // Most negative sample saturates to full-scale magnitude.
    cfg(32767, 0, 0);
    step(0, 0, 1);
    step(1, -32768, 0);
    chk("c_valid", 64'(bus.valid), 64'(1));
    chk("c_tof",   64'(bus.tof),   64'(0));
    chk("c_peak",  64'(bus.peak),  64'(32767));

    // Reset mid-window wins over start/en; later samples ignored.
    cfg(1000, 0, 0);
    step(0, 0, 1);
    step(1, 200, 0);
    step(1, 300, 0);
    step(1, -400, 0);
    chk("d_peak_pre", 64'(bus.peak), 64'(400));
    step(1, 2000, 1, 1);
    chk("d_busy", 64'(bus.busy), 64'(0));
    chk("d_peak", 64'(bus.peak), 64'(0));
    chk("d_tof",  64'(bus.tof),  64'(0));
    cfg(100, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 5000, 0);
    chk("d_ign", 64'(bus.valid), 64'(0));

    // Restart at index 2: start beats the same-cycle sample.
    cfg(500, 0, 0);
    step(0, 0, 1);
    step(1, 100, 0);
    step(1, 200, 0);
    step(1, 900, 1);
    chk("e_peak0", 64'(bus.peak), 64'(0));
    chk("e_busy",  64'(bus.busy), 64'(1));
    step(1, 300, 0);
    step(1, 600, 0);
    chk("e_valid", 64'(bus.valid), 64'(1));
    chk("e_tof",   64'(bus.tof),   64'(1));
    chk("e_peak",  64'(bus.peak),  64'(600));
    step(1, 700, 0);
    chk("e_once",  64'(bus.valid), 64'(0));

    // blank >= timeout: expires while still blanking, nothing compared.
    cfg(0, 5, 3);
    step(0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 9999, 0);
    chk("f_to",   64'(bus.timed_out), 64'(1));
    chk("f_peak", 64'(bus.peak),      64'(0));

    // Hit on the last sample of the window beats the timeout.
    cfg(100, 0, 2);
    step(0, 0, 1);
    step(1, 10, 0);
    step(1, -200, 0);
    chk("g_valid", 64'(bus.valid),     64'(1));
    chk("g_to",    64'(bus.timed_out), 64'(0));
    chk("g_tof",   64'(bus.tof),       64'(1));
`else
    // Averaged magnitude: 400 alone averages to 100 and hits.
    cfg(100, 0, 0);
    step(0, 0, 1);
    step(1, 400, 0);
    chk("h_valid", 64'(bus.valid), 64'(1));
    chk("h_tof",   64'(bus.tof),   64'(0));
    chk("h_peak",  64'(bus.peak),  64'(100));
    step(0, 0, 1);
    step(1, 200, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    chk("h_nohit", 64'(bus.valid), 64'(0));
    chk("h_peak2", 64'(bus.peak),  64'(50));
    chk("h_busy",  64'(bus.busy),  64'(1));

    // History spans blanked samples: third sample sees (300+300+300)/4 = 225.
    cfg(200, 2, 0);
    step(0, 0, 1);
    step(1, 300, 0);
    step(1, 300, 0);
    step(1, 300, 0);
    chk("h_blank_hist", 64'(bus.valid), 64'(1));
    chk("h_blank_tof",  64'(bus.tof),   64'(2));
`endif

    // Mixed directed sweep covered by the per-cycle model compare.
    cfg(3000, 1, 12);
    step(0, 0, 1);
    for (int i = 0; i < 14; i++) step((i % 3) != 2, (i * 977) % 2900 - 1400, 0);
    cfg(1200, 3, 0);
    step(0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, -150 * i, 0);
    step(0, 0, 0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
